// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
// Holds the sequencer state encoding, the NOP instruction and the reset values.
// Imported by mem_arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    F_REQ  = 3'd1,
    F_WAIT = 3'd2,
    EXEC   = 3'd3,
    D_REQ  = 3'd4,
    D_WAIT = 3'd5,
    COMMIT = 3'd6
  } state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam state_t RST_STATE = IDLE;
  localparam logic   RST_STALL = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/grant/response bus between the arbiter and unified memory.
// Latency: n/a (wires only). Backpressure: req held until gnt; rvalid completes the access.
// Signals: req/we/addr/wdata from master; gnt/rvalid/rdata from slave (memory).
interface mem_arbiter_if #(
  parameter int N = 64
);
  logic         req;
  logic         we;
  logic [N-1:0] addr;
  logic [N-1:0] wdata;
  logic         gnt;
  logic         rvalid;
  logic [N-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_arbiter_watchdog.sv
// arb_watchdog: counts cycles spent in one bus transaction phase and flags expiry.
// Latency: expired is combinational in the TIMEOUT-th enabled cycle after a clear.
// Backpressure: none. Ports: clk, reset (sync, active-low), clear, enable, expired.
module arb_watchdog #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  assign expired = enable && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences fetch, optional data access and commit over one shared memory port.
// Latency: 4 cycles per instruction without memory access, 6 with one (gnt immediate, rvalid +1).
// Backpressure: stall held high except in COMMIT; bus req held until gnt, then waits for rvalid.
// Ports: clk, reset (sync, active-low); IM_* / DM_* datapath side; bus (mem_arbiter_if.master);
// stall to datapath; timeout_err sticky watchdog flag.
// Build option: MEM_ARB_TIMEOUT_EN enables the TIMEOUT-cycle bus watchdog (otherwise timeout_err=0).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N       = 64,
  parameter int TIMEOUT = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  IM_addr,
  output logic [31:0]   IM_readData,
  input  logic [N-1:0]  DM_addr,
  input  logic [N-1:0]  DM_writeData,
  input  logic          DM_readEnable,
  input  logic          DM_writeEnable,
  output logic [N-1:0]  DM_readData,
  output logic          stall,
  mem_arbiter_if.master bus,
  output logic          timeout_err
);

  state_t       state_q, state_d;
  logic [N-1:0] addr_q;
  logic [N-1:0] wdata_q;
  logic         we_q;
  logic         wd_expired;

  assign stall     = (state_q == COMMIT) ? 1'b0 : RST_STALL;
  assign bus.req   = (state_q == F_REQ) || (state_q == D_REQ);
  assign bus.we    = we_q;
  assign bus.wdata = wdata_q;
  // The PC advances on the edge that leaves COMMIT, so the fetch address is taken
  // straight from IM_addr while in F_REQ (stall keeps it stable until gnt).
  assign bus.addr  = (state_q == F_REQ) ? IM_addr : addr_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = F_REQ;
      F_REQ:   if (bus.gnt)    state_d = F_WAIT;
      F_WAIT:  if (bus.rvalid) state_d = EXEC;
      EXEC:    state_d = (DM_readEnable || DM_writeEnable) ? D_REQ : COMMIT;
      D_REQ:   if (bus.gnt)    state_d = D_WAIT;
      D_WAIT:  if (bus.rvalid) state_d = COMMIT;
      COMMIT:  state_d = F_REQ;
      default: state_d = IDLE;
    endcase
    if (wd_expired) state_d = COMMIT;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RST_STATE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      IM_readData <= NOP_INSTR;
      DM_readData <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE, COMMIT: we_q <= 1'b0;
        F_REQ:        addr_q <= IM_addr;
        F_WAIT:       if (bus.rvalid) IM_readData <= bus.rdata[31:0];
        EXEC: begin
          if (DM_readEnable || DM_writeEnable) begin
            addr_q  <= DM_addr;
            wdata_q <= DM_writeData;
            we_q    <= DM_writeEnable;  // write wins when both enables are set
          end
        end
        D_WAIT:       if (bus.rvalid && !we_q) DM_readData <= bus.rdata;
        default:      ;
      endcase
      if (wd_expired) begin
        if ((state_q == F_REQ) || (state_q == F_WAIT)) IM_readData <= NOP_INSTR;
        else                                           DM_readData <= '0;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic in_bus;
  logic wd_clear;
  logic err_q;

  assign in_bus   = state_q inside {F_REQ, F_WAIT, D_REQ, D_WAIT};
  // Restart the count on every entry into a new bus phase.
  assign wd_clear = (state_d != state_q) && (state_d inside {F_REQ, F_WAIT, D_REQ, D_WAIT});

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (in_bus),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset)          err_q <= 1'b0;
    else if (wd_expired) err_q <= 1'b1;
  end

  assign timeout_err = err_q;
`else
  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
